// File: rtl/fs_wren_sched.sv
// Floyd-Steinberg write-enable sequencer: one centre write plus four masked,
// direction-mirrored neighbour writes per pixel, stalled while the MCU owns the RAM.
module fs_wren_sched #(
  parameter int IMAGEY           = 64,
  parameter int IMAGEX           = 64,
  parameter int IMAGE_SIZE       = IMAGEY * IMAGEX,
  parameter int IMAGEXlog2       = $clog2(IMAGEX),
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
  parameter int ADJ_PIXELS       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [IMAGE_ADDR_WIDTH-1:0] png_idx,
  input  logic                        dir_rl,
  input  logic                        MCU_TX_RDY,
  output logic                        wren_a,
  output logic [IMAGE_ADDR_WIDTH-1:0] addr_a,
  output logic [2:0]                  slot,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int AW  = IMAGE_ADDR_WIDTH;
  localparam int AWP = IMAGE_ADDR_WIDTH + 1;
  localparam int XL  = IMAGEXlog2;
  localparam int YW  = IMAGE_ADDR_WIDTH - IMAGEXlog2;
  localparam logic [AW:0]   ROW_STEP = AWP'(IMAGEX);
  localparam logic [AW:0]   SIZE_W   = AWP'(IMAGE_SIZE);
  localparam logic [2:0]    LAST_SLOT = 3'(ADJ_PIXELS);
  localparam logic [XL-1:0] X_MAX    = XL'(IMAGEX - 1);
  localparam logic [YW-1:0] Y_MAX    = YW'(IMAGEY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  state_t        state_q;
  logic [AW-1:0] pix_q;
  logic          dir_q;
  logic          issued_q;
  logic          wren_q, busy_q, done_q, err_q;
  logic [AW-1:0] addr_q;
  logic [2:0]    slot_q;

  logic [AW:0]   p_ext;
  logic [XL-1:0] col;
  logic [YW-1:0] row;
  logic          x_first, x_last, y_last;
  logic [2:0]    nxt_slot;
  logic [AW:0]   nxt_sum;
  logic          nxt_ok;
  logic          nxt_wren;
  logic          idx_valid;

  assign p_ext   = {1'b0, pix_q};
  assign col     = pix_q[XL-1:0];
  assign row     = pix_q[AW-1:XL];
  assign x_first = (col == '0);
  assign x_last  = (col == X_MAX);
  assign y_last  = (row >= Y_MAX);

  assign idx_valid = ({1'b0, png_idx} < SIZE_W);

  // A slot blocked by a stall is re-presented rather than skipped.
  assign nxt_slot = issued_q ? slot_q + 3'd1 : slot_q;

  always_comb begin
    nxt_sum = p_ext;
    nxt_ok  = 1'b0;
    case (nxt_slot)
      3'd0: begin
        nxt_sum = p_ext;
        nxt_ok  = 1'b1;
      end
      3'd1: begin
        if (dir_q) begin
          nxt_sum = p_ext - 1'b1;
          nxt_ok  = !x_first;
        end else begin
          nxt_sum = p_ext + 1'b1;
          nxt_ok  = !x_last;
        end
      end
      3'd2: begin
        if (dir_q) begin
          nxt_sum = p_ext + ROW_STEP + 1'b1;
          nxt_ok  = !y_last && !x_last;
        end else begin
          nxt_sum = p_ext + ROW_STEP - 1'b1;
          nxt_ok  = !y_last && !x_first;
        end
      end
      3'd3: begin
        nxt_sum = p_ext + ROW_STEP;
        nxt_ok  = !y_last;
      end
      3'd4: begin
        if (dir_q) begin
          nxt_sum = p_ext + ROW_STEP - 1'b1;
          nxt_ok  = !y_last && !x_first;
        end else begin
          nxt_sum = p_ext + ROW_STEP + 1'b1;
          nxt_ok  = !y_last && !x_last;
        end
      end
      default: begin
        nxt_sum = p_ext;
        nxt_ok  = 1'b0;
      end
    endcase
  end

  // The carry bit can only be set on a masked slot; folding it in is a backstop.
  assign nxt_wren = nxt_ok && !nxt_sum[AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pix_q    <= '0;
      dir_q    <= 1'b0;
      issued_q <= 1'b0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      slot_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_WRITE: begin
          if (MCU_TX_RDY) begin
            wren_q <= 1'b0;
          end else if (issued_q && (slot_q == LAST_SLOT)) begin
            state_q <= S_DONE;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            slot_q   <= nxt_slot;
            addr_q   <= nxt_sum[AW-1:0];
            wren_q   <= nxt_wren;
            issued_q <= 1'b1;
          end
        end
        default: begin
          wren_q <= 1'b0;
          busy_q <= 1'b0;
          if (start && idx_valid) begin
            state_q  <= S_WRITE;
            pix_q    <= png_idx;
            dir_q    <= dir_rl;
            slot_q   <= '0;
            addr_q   <= png_idx;
            busy_q   <= 1'b1;
            wren_q   <= !MCU_TX_RDY;
            issued_q <= !MCU_TX_RDY;
          end else begin
            state_q <= S_IDLE;
            err_q   <= start;
          end
        end
      endcase
    end
  end

  assign wren_a = wren_q;
  assign addr_a = addr_q;
  assign slot   = slot_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_fs_wren_sched.sv
// Directed bench for fs_wren_sched: 64x64 instance for sequencing/masking/stall/reset,
// 48x64 instance for out-of-range index rejection.
module tb_fs_wren_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, dir_rl, mcu_tx_rdy;
  logic [11:0] png_idx;
  logic        wren_a, busy, done, err;
  logic [11:0] addr_a;
  logic [2:0]  slot;

  logic        start2;
  logic [11:0] png_idx2;
  logic        wren2, busy2, done2, err2;
  logic [11:0] addr2;
  logic [2:0]  slot2;

  int n_chk  = 0;
  int n_pass = 0;
  int wr_cnt = 0;

  always #5 clk = ~clk;

  fs_wren_sched #(.IMAGEY(64), .IMAGEX(64)) dut (
    .clk(clk), .rst(rst), .start(start), .png_idx(png_idx), .dir_rl(dir_rl),
    .MCU_TX_RDY(mcu_tx_rdy), .wren_a(wren_a), .addr_a(addr_a), .slot(slot),
    .busy(busy), .done(done), .err(err)
  );

  fs_wren_sched #(.IMAGEY(48), .IMAGEX(64)) dut48 (
    .clk(clk), .rst(rst), .start(start2), .png_idx(png_idx2), .dir_rl(1'b0),
    .MCU_TX_RDY(1'b0), .wren_a(wren2), .addr_a(addr2), .slot(slot2),
    .busy(busy2), .done(done2), .err(err2)
  );

  always @(negedge clk) if (wren_a) wr_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seq_pixel(input string tag, input int p, input bit d,
                           input int ea[5], input bit ew[5]);
    start = 1'b1; png_idx = 12'(p); dir_rl = d;
    tick();
    start = 1'b0;
    for (int s = 0; s < 5; s++) begin
      chk({tag, "/slot"}, int'(slot), s);
      chk({tag, "/wren"}, int'(wren_a), int'(ew[s]));
      if (ew[s]) chk({tag, "/addr"}, int'(addr_a), ea[s]);
      chk({tag, "/busy"}, int'(busy), 1);
      chk({tag, "/done_early"}, int'(done), 0);
      if (s < 4) tick();
    end
    tick();
    chk({tag, "/done"}, int'(done), 1);
    chk({tag, "/busy_off"}, int'(busy), 0);
    chk({tag, "/wren_off"}, int'(wren_a), 0);
  endtask

  initial begin
    int w0;
    rst = 1'b1; start = 1'b0; dir_rl = 1'b0; mcu_tx_rdy = 1'b0; png_idx = '0;
    start2 = 1'b0; png_idx2 = '0;
    tick(); tick();
    chk("rst/wren", int'(wren_a), 0);
    chk("rst/addr", int'(addr_a), 0);
    chk("rst/slot", int'(slot), 0);
    chk("rst/busy", int'(busy), 0);
    chk("rst/done", int'(done), 0);
    chk("rst/err", int'(err), 0);
    rst = 1'b0;
    tick();

    // interior pixel, then back-to-back edge cases starting in each done cycle
    seq_pixel("p65", 65, 1'b0, '{65, 66, 128, 129, 130}, '{1, 1, 1, 1, 1});
    seq_pixel("p63", 63, 1'b0, '{63, 0, 126, 127, 0}, '{1, 0, 1, 1, 0});
    seq_pixel("p4095", 4095, 1'b0, '{4095, 0, 0, 0, 0}, '{1, 0, 0, 0, 0});
    seq_pixel("p64rl", 64, 1'b1, '{64, 0, 129, 128, 0}, '{1, 0, 1, 1, 0});
    seq_pixel("p130rl", 130, 1'b1, '{130, 129, 195, 194, 193}, '{1, 1, 1, 1, 1});
    seq_pixel("p4032", 4032, 1'b0, '{4032, 4033, 0, 0, 0}, '{1, 1, 0, 0, 0});
    tick();
    chk("idle/done", int'(done), 0);
    chk("idle/busy", int'(busy), 0);

    // stall of three edges after slot 1
    w0 = wr_cnt;
    start = 1'b1; png_idx = 12'd65; dir_rl = 1'b0;
    tick();
    start = 1'b0;
    chk("stall/s0", int'(addr_a), 65);
    tick();
    chk("stall/s1", int'(addr_a), 66);
    mcu_tx_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall/wren", int'(wren_a), 0);
      chk("stall/slot_hold", int'(slot), 1);
      chk("stall/addr_hold", int'(addr_a), 66);
      chk("stall/busy", int'(busy), 1);
      chk("stall/done", int'(done), 0);
    end
    mcu_tx_rdy = 1'b0;
    tick();
    chk("stall/resume_slot", int'(slot), 2);
    chk("stall/resume_addr", int'(addr_a), 128);
    chk("stall/resume_wren", int'(wren_a), 1);
    tick();
    chk("stall/s3", int'(addr_a), 129);
    tick();
    chk("stall/s4", int'(addr_a), 130);
    chk("stall/done_pre", int'(done), 0);
    tick();
    chk("stall/done9", int'(done), 1);
    chk("stall/writes", wr_cnt - w0, 5);
    tick();

    // start while busy must be ignored and not queued
    start = 1'b1; png_idx = 12'd65; dir_rl = 1'b0;
    tick();
    png_idx = 12'd200; dir_rl = 1'b1;
    tick(); tick();
    chk("busy_start/s2", int'(addr_a), 128);
    tick();
    start = 1'b0;
    chk("busy_start/s3", int'(addr_a), 129);
    tick();
    chk("busy_start/s4", int'(addr_a), 130);
    tick();
    chk("busy_start/done", int'(done), 1);
    tick();
    chk("busy_start/no_queue", int'(busy), 0);

    // reset in slot 2 aborts, then P=0 runs normally
    w0 = wr_cnt;
    start = 1'b1; png_idx = 12'd65; dir_rl = 1'b0;
    tick(); start = 1'b0;
    tick(); tick();
    chk("rstmid/at_s2", int'(slot), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid/wren", int'(wren_a), 0);
    chk("rstmid/addr", int'(addr_a), 0);
    chk("rstmid/slot", int'(slot), 0);
    chk("rstmid/busy", int'(busy), 0);
    chk("rstmid/done", int'(done), 0);
    chk("rstmid/err", int'(err), 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rstmid/no_done", int'(done), 0);
      chk("rstmid/idle_busy", int'(busy), 0);
    end
    chk("rstmid/writes", wr_cnt - w0, 3);
    seq_pixel("p0", 0, 1'b0, '{0, 1, 0, 64, 65}, '{1, 1, 0, 1, 1});
    tick();

    // 48x64: index beyond IMAGE_SIZE is rejected with a one-cycle err
    start2 = 1'b1; png_idx2 = 12'd3100;
    tick();
    start2 = 1'b0;
    chk("err/pulse", int'(err2), 1);
    chk("err/busy", int'(busy2), 0);
    chk("err/wren", int'(wren2), 0);
    tick();
    chk("err/one_cycle", int'(err2), 0);
    chk("err/still_idle", int'(busy2), 0);
    start2 = 1'b1; png_idx2 = 12'd3071;
    tick();
    start2 = 1'b0;
    chk("y48/err", int'(err2), 0);
    chk("y48/busy", int'(busy2), 1);
    chk("y48/addr", int'(addr2), 3071);
    chk("y48/wren", int'(wren2), 1);
    tick();
    chk("y48/e_masked", int'(wren2), 0);
    tick();
    chk("y48/sw_masked", int'(wren2), 0);
    tick(); tick(); tick();
    chk("y48/done", int'(done2), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
